// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter that commits one requester's data into a shared enable-gated register.
// Optional owner lock-in when LOCK_EN is defined.
module dff_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
`ifdef LOCK_EN
  input  logic [NUM_REQ-1:0]         lock,
`endif
  output logic [NUM_REQ-1:0]         gnt,
  output logic [DATA_W-1:0]          q,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StWrite, StAck} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              locked_q, locked_d;
  logic              lock_hit;
  logic              lock_owner;
  logic [IdxW-1:0]   rr_win, win;
  logic [DATA_W-1:0] win_lane;

  // First set request scanning upward from ptr with wrap.
  always_comb begin
    int unsigned k;
    logic        found;
    rr_win = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        rr_win = IdxW'(k);
      end
    end
  end

`ifdef LOCK_EN
  assign lock_hit   = locked_q && req[owner_q];
  assign lock_owner = lock[owner_q];
`else
  assign lock_hit   = 1'b0;
  assign lock_owner = 1'b0;
`endif

  assign win = lock_hit ? owner_q : rr_win;

  always_comb begin
    win_lane = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IdxW'(i) == win) win_lane = wdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    q_d      = q_q;
    locked_d = locked_q;
    unique case (state_q)
      StIdle: begin
        // A lock survives IDLE only while its owner keeps requesting.
        locked_d = lock_hit;
        if (|req) begin
          owner_d = win;
          hold_d  = win_lane;
          state_d = StWrite;
        end
      end
      StWrite: begin
        q_d     = hold_q;
        state_d = StAck;
      end
      StAck: begin
        locked_d = lock_owner;
        if (!lock_owner) begin
          ptr_d = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Clear wins over everything but leaves the arbitration history intact.
    if (clr) begin
      q_d      = '0;
      state_d  = StIdle;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      hold_d   = hold_q;
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
      q_q      <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      q_q      <= q_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == StAck) gnt[owner_q] = 1'b1;
  end

  assign q     = q_q;
  assign busy  = (state_q != StIdle);
  assign owner = owner_q;

endmodule
